// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared pointer helpers for the async FIFO write/read blocks
//
// Contents:
//   FIFO_AW  default address width of the FIFO
//   DEPTH    default FIFO depth (2**FIFO_AW)
//   PTR_MAX  widest pointer the helpers handle
//   bin2gray binary -> Gray conversion; callers zero-extend to PTR_MAX bits
//            and size-cast the result back to their own pointer width
//   gray2bin Gray -> binary conversion; same calling convention, so the
//            zero-extension keeps the upper prefix XOR at zero
package fifo_pkg;

  localparam int FIFO_AW = 8;
  localparam int DEPTH   = 1 << FIFO_AW;
  localparam int PTR_MAX = 32;

  function automatic logic [PTR_MAX-1:0] bin2gray(input logic [PTR_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_MAX-1:0] gray2bin(input logic [PTR_MAX-1:0] g);
    logic [PTR_MAX-1:0] b;
    b[PTR_MAX-1] = g[PTR_MAX-1];
    for (int i = PTR_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/synchronizer_w.sv
// rtl/synchronizer_w.sv - two-flop synchronizer bringing the Gray read pointer into wclk
//
// Ports:
//   wclk      write-domain clock
//   wrst_n    asynchronous active-low reset
//   rptr      Gray read pointer from the read domain (asynchronous to wclk)
//   wq2_rptr  read pointer after two wclk flops
module synchronizer_w #(
  parameter int width = 8
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic [width:0]   rptr,
  output logic [width:0]   wq2_rptr
);

  logic [width:0] wq1_rptr;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wq1_rptr <= '0;
      wq2_rptr <= '0;
    end else begin
      wq1_rptr <= rptr;
      wq2_rptr <= wq1_rptr;
    end
  end

endmodule

// File: rtl/fifo_wptr_full.sv
// rtl/fifo_wptr_full.sv - write pointer, RAM write address and full flag of the async FIFO
//
// Optional feature: define ALMOST_FULL_EN to add the registered wafull output.
//
// Parameters:
//   width      address bits; depth is 2**width, pointers are width+1 bits
//   AF_MARGIN  free-slot threshold for wafull (only with ALMOST_FULL_EN)
//
// Ports:
//   wclk       write-domain clock
//   wrst_n     asynchronous active-low reset, clears every flop
//   winc       write request; accepted when wfull is low
//   rptr       Gray read pointer from the read domain
//   waddr      RAM write address (low bits of the binary write pointer)
//   wptr       registered Gray write pointer for the read domain
//   wfull      registered full flag
//   woverflow  sticky: a write was attempted while full
//   wafull     registered almost-full flag (ALMOST_FULL_EN only)
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int width     = FIFO_AW,
  parameter int AF_MARGIN = 2
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic             winc,
  input  logic [width:0]   rptr,
  output logic [width-1:0] waddr,
  output logic [width:0]   wptr,
  output logic             wfull,
  output logic             woverflow
`ifdef ALMOST_FULL_EN
  ,
  output logic             wafull
`endif
);

  localparam int PW = width + 1;

  logic [width:0] wbin;
  logic [width:0] wbinnext;
  logic [width:0] wgraynext;
  logic [width:0] wq2_rptr;
  logic           wfull_next;

  synchronizer_w #(
    .width(width)
  ) u_sync (
    .wclk     (wclk),
    .wrst_n   (wrst_n),
    .rptr     (rptr),
    .wq2_rptr (wq2_rptr)
  );

  // Full is judged on the next-state pointer so the flag rises on the same
  // edge as the write that takes the last slot: the Gray write pointer equals
  // the synchronized read pointer with its two top bits inverted.
  always_comb begin
    wbinnext   = wbin + PW'(winc & ~wfull);
    wgraynext  = PW'(bin2gray(PTR_MAX'(wbinnext)));
    wfull_next = (wgraynext == {~wq2_rptr[width:width-1], wq2_rptr[width-2:0]});
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin      <= '0;
      wptr      <= '0;
      wfull     <= 1'b0;
      woverflow <= 1'b0;
    end else begin
      wbin      <= wbinnext;
      wptr      <= wgraynext;
      wfull     <= wfull_next;
      woverflow <= woverflow | (winc & wfull);
    end
  end

  assign waddr = wbin[width-1:0];

`ifdef ALMOST_FULL_EN
  localparam logic [width:0] AF_LEVEL = PW'((1 << width) - AF_MARGIN);

  logic [width:0] rbin_s;
  logic [width:0] used;

  // Occupancy is taken modulo 2**(width+1); the stale synchronized read
  // pointer only ever overstates it, so the flag errs towards early warning.
  always_comb begin
    rbin_s = PW'(gray2bin(PTR_MAX'(wq2_rptr)));
    used   = wbinnext - rbin_s;
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wafull <= 1'b0;
    end else begin
      wafull <= (used >= AF_LEVEL);
    end
  end
`endif

endmodule

// File: doc/fifo_wptr_full.md
Name: fifo_wptr_full

Overview:
- Write-side pointer and full-flag block of the async FIFO used between the UART core clock and the host clock.
- Counterpart of the read-domain write-pointer synchronizer: it owns the write pointer and brings the read pointer into the write clock domain.
- Produces the write address for the dual-port RAM, the Gray write pointer sent to the read domain, and a registered full flag.
- Accepts writes only while not full.

Parameters:
- width, 8: address bits; FIFO depth = 2**width; pointers are width+1 bits; legal range width >= 2.
- AF_MARGIN, 2: free-slot threshold for almost-full (used only with ALMOST_FULL_EN); legal range 1..2**width-1.

Ports:
- wclk  input  1  write-domain clock.
- wrst_n  input  1  reset; asynchronous, active-low. Applied to all flops, including the internal synchronizer.
- winc  input  1  write request; a write is accepted on a wclk edge when winc=1 and wfull=0.
- rptr  input  width+1  Gray read pointer from the read domain; asynchronous to wclk.
- waddr  output  width  RAM write address = wbin[width-1:0].
- wptr  output  width+1  registered Gray write pointer, sent to the read domain.
- wfull  output  1  registered full flag.
- woverflow  output  1  sticky flag: a write was attempted while full.
- wafull  output  1  almost-full flag; present only with ALMOST_FULL_EN.

Behaviour:
- Reset (wrst_n=0, async): wbin=0, wptr=0, wfull=0, woverflow=0, wafull=0, synchronizer stages=0. Therefore waddr=0.
- rptr passes through two wclk flops to give wq2_rptr. Nothing in this block uses rptr without that synchronization.
- Next-state values each cycle:
  - wbinnext = wbin + (winc & ~wfull), modulo 2**(width+1).
  - wgraynext = wbinnext ^ (wbinnext >> 1).
- On each wclk edge: wbin <= wbinnext; wptr <= wgraynext.
- Write latency: one accepted write advances waddr and wptr on the same edge. The RAM write uses the old waddr.
- Full:
  - wfull <= (wgraynext == {~wq2_rptr[width:width-1], wq2_rptr[width-2:0]}).
  - Full is computed from the next-state pointer, so wfull asserts on the same edge as the write that fills the last slot.
- Write while full: pointer holds, RAM write must not occur, woverflow <= 1. woverflow stays set until reset.
- Release from full:
  - After the read domain advances rptr, wfull deasserts no earlier than the 3rd wclk edge after rptr is stable.
  - This latency (2 sync edges + 1 registered flag) is pessimistic by design and is not an error.
- Wrap-around: wbin rolls from 2**(width+1)-1 to 0 with no special case. The extra MSB separates full from empty.
- Simultaneous write and read-pointer change: the write is judged against the wq2_rptr value visible on that edge.
- Reset mid-operation: all state clears immediately, asynchronously. The read domain must also be reset; the block does not detect a one-sided reset.
- Only one bit of wptr may change per wclk edge. This holds by construction; the bench checks it.

Optional Feature:
- Macro: ALMOST_FULL_EN.
- Defined:
  - Convert wq2_rptr from Gray to binary to get rbin_s.
  - used = (wbinnext - rbin_s) mod 2**(width+1).
  - wafull <= (used >= 2**width - AF_MARGIN).
  - wafull is registered, resets to 0, and is always asserted whenever wfull=1.
- Not defined: no wafull port, no Gray-to-binary logic; AF_MARGIN is ignored.

Decomposition:
- Shared package fifo_pkg:
  - bin2gray and gray2bin functions, parameterised by width.
  - Localparam for DEPTH.
  - Reused by the read-side empty block.
- Sub-module synchronizer_w:
  - 2-flop, width+1 wide, clocked by wclk/wrst_n.
  - Mirror of the read-domain synchronizer; instantiated once.

Test Plan (width=3, depth 8, AF_MARGIN=2, rptr held at 0 unless stated):
- Reset: wrst_n=0 mid-cycle, with winc=1 -> waddr=0, wptr=0, wfull=0, woverflow=0 immediately, not waiting for a clock edge.
- Fill: 8 consecutive cycles of winc=1 -> waddr steps 0..7 then back to 0. wptr after 8 writes = 4'b1100. wfull=1 on the edge of the 8th write.
- Overflow: with wfull=1, pulse winc for 1 cycle -> wptr holds 4'b1100, woverflow=1 and stays 1 until reset.
- Release: from full, set rptr=4'b0001 (one read) -> wfull=0 on the 3rd wclk edge after the change, not earlier. One further write then re-asserts wfull.
- Wrap: 20 writes interleaved with matching rptr Gray updates -> wptr changes exactly one bit per accepted write, wbin wraps 15 -> 0, wfull never asserts.
- ALMOST_FULL_EN: 6 writes with rptr=0 -> wafull=1 on the 6th write edge, wfull=0. 2 more writes -> both flags 1.
